// File: rtl/dl_bitwise_pkg.sv
// Shared types and constants for the dl_bitwise_acc block: op encoding,
// controller state encoding and beat-counter width.
package dl_bitwise_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int BEAT_W = 16;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

endpackage

// File: rtl/dl_bitwise_op.sv
// Single-lane bitwise combine: y = a <op> b, with PASS returning b.
// Purely combinational; one instance per lane in dl_bitwise_acc.
module dl_bitwise_op
  import dl_bitwise_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  op_e                 op,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic [NUM_BITS-1:0] y
);

  always_comb begin
    y = b;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_PASS: y = b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/dl_bitwise_acc.sv
// Per-lane bitwise reduction of a valid/ready packet stream with a saturating beat count.
// Optional per-lane popcount of the result is enabled by DL_BITWISE_ACC_POPCNT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for first beat; it loads acc, op and the beat count
// ST_ACC  | folding further beats into acc with the latched op
// ST_DONE | result presented on out_*; input stalled until out handshake
module dl_bitwise_acc
  import dl_bitwise_pkg::*;
#(
  parameter int NUM_BITS  = 32,
  parameter int NUM_LANES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    op,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES*NUM_BITS-1:0] in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*NUM_BITS-1:0] out_data,
  output logic [BEAT_W-1:0]             out_beats
`ifdef DL_BITWISE_ACC_POPCNT_EN
  ,
  output logic [NUM_LANES*$clog2(NUM_BITS+1)-1:0] out_popcnt
`endif
);

  localparam int W = NUM_LANES * NUM_BITS;

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_sel;
  logic [W-1:0]      acc_q, acc_d, lane_y;
  logic [BEAT_W-1:0] beats_q, beats_d, beats_inc;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [BEAT_W-1:0] out_beats_q, out_beats_d;
  logic              load_out;

  // The first beat of a packet always loads, so the lanes run in PASS mode in IDLE.
  assign op_sel    = (state_q == ST_IDLE) ? OP_PASS : op_q;
  assign beats_inc = (beats_q == BEAT_MAX) ? beats_q : beats_q + BEAT_W'(1);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dl_bitwise_op #(
      .NUM_BITS(NUM_BITS)
    ) u_op (
      .op(op_sel),
      .a (acc_q[k*NUM_BITS +: NUM_BITS]),
      .b (in_data[k*NUM_BITS +: NUM_BITS]),
      .y (lane_y[k*NUM_BITS +: NUM_BITS])
    );
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    load_out    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = lane_y;
          op_d    = op_e'(op);
          beats_d = BEAT_W'(1);
          if (in_last) begin
            load_out = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = lane_y;
          beats_d = beats_inc;
          if (in_last) begin
            load_out = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_out) begin
      out_data_d  = acc_d;
      out_beats_d = beats_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      acc_q       <= '0;
      beats_q     <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

`ifdef DL_BITWISE_ACC_POPCNT_EN
  localparam int PCW = $clog2(NUM_BITS + 1);

  logic [NUM_LANES*PCW-1:0] popcnt_q, popcnt_d;

  // Counted from the final accumulator value so it lands in the same cycle as out_data.
  always_comb begin
    popcnt_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int b = 0; b < NUM_BITS; b++) begin
        popcnt_d[l*PCW +: PCW] = popcnt_d[l*PCW +: PCW] + PCW'(acc_d[l*NUM_BITS + b]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      popcnt_q <= '0;
    end else if (load_out) begin
      popcnt_q <= popcnt_d;
    end
  end

  assign out_popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_dl_bitwise_acc.sv
// Directed self-checking bench for dl_bitwise_acc with NUM_BITS=8, NUM_LANES=2.
// Popcount checks are compiled in when DL_BITWISE_ACC_POPCNT_EN is defined.
module tb_dl_bitwise_acc;

  logic        clk;
  logic        rst;
  logic [1:0]  op;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_beats;
`ifdef DL_BITWISE_ACC_POPCNT_EN
  logic [7:0]  out_popcnt;
`endif

  int checks = 0;
  int errors = 0;

  dl_bitwise_acc #(
    .NUM_BITS (8),
    .NUM_LANES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_beats(out_beats)
`ifdef DL_BITWISE_ACC_POPCNT_EN
    ,
    .out_popcnt(out_popcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [1:0] o, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    op       = o;
    in_last  = l;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data got=%h exp=0000", out_data);
    end
    checks++;
    if (out_beats !== 16'h0000) begin
      errors++; $display("FAIL reset_beats got=%h exp=0000", out_beats);
    end
`ifdef DL_BITWISE_ACC_POPCNT_EN
    checks++;
    if (out_popcnt !== 8'h00) begin
      errors++; $display("FAIL reset_popcnt got=%h exp=00", out_popcnt);
    end
`endif
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_single_or();
    send_beat(16'h0F30, 2'b01, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got=%0b exp=1", out_valid);
    end
    checks++;
    if (out_data !== 16'h0F30) begin
      errors++; $display("FAIL single_data got=%h exp=0F30", out_data);
    end
    checks++;
    if (out_beats !== 16'd1) begin
      errors++; $display("FAIL single_beats got=%0d exp=1", out_beats);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL single_in_ready_done got=%0b exp=0", in_ready);
    end
`ifdef DL_BITWISE_ACC_POPCNT_EN
    checks++;
    if (out_popcnt !== 8'h42) begin
      errors++; $display("FAIL single_popcnt got=%h exp=42", out_popcnt);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_after_hs got=%0b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0F30) begin
      errors++; $display("FAIL single_data_retained got=%h exp=0F30", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready_idle got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_xor_op_ignored();
    send_beat(16'hFF00, 2'b10, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL xor_valid_mid got=%0b exp=0", out_valid);
    end
    send_beat(16'h0F0F, 2'b00, 1'b0);
    send_beat(16'hF0F0, 2'b00, 1'b1);
    checks++;
    if (out_data !== 16'h00FF) begin
      errors++; $display("FAIL xor_data got=%h exp=00FF", out_data);
    end
    checks++;
    if (out_beats !== 16'd3) begin
      errors++; $display("FAIL xor_beats got=%0d exp=3", out_beats);
    end
`ifdef DL_BITWISE_ACC_POPCNT_EN
    checks++;
    if (out_popcnt !== 8'h08) begin
      errors++; $display("FAIL xor_popcnt got=%h exp=08", out_popcnt);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int hs;
    hs = 0;
    out_ready = 1'b0;
    send_beat(16'hFFAA, 2'b00, 1'b0);
    send_beat(16'h0FFF, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0FAA || out_beats !== 16'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%0b data=%h beats=%0d exp valid=1 data=0FAA beats=2",
                 i, out_valid, out_data, out_beats);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready);
      end
      tick();
    end
`ifdef DL_BITWISE_ACC_POPCNT_EN
    checks++;
    if (out_popcnt !== 8'h44) begin
      errors++; $display("FAIL bp_popcnt got=%h exp=44", out_popcnt);
    end
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid && out_ready) hs++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (hs != 1) begin
      errors++; $display("FAIL bp_handshakes got=%0d exp=1", hs);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic seen;
    send_beat(16'h1111, 2'b01, 1'b0);
    send_beat(16'h2222, 2'b01, 1'b0);
    #1;
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_beats !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_clear valid=%0b data=%h beats=%h exp 0/0000/0000",
               out_valid, out_data, out_beats);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_ready got=%0b exp=1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_output got=%0b exp=0", seen);
    end
    send_beat(16'h1234, 2'b10, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_beats !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_next valid=%0b data=%h beats=%0d exp 1/1234/1",
               out_valid, out_data, out_beats);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_beat(16'h1111, 2'b11, 1'b0);
    send_beat(16'h2222, 2'b11, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_beats !== 16'd2) begin
      errors++;
      $display("FAIL b2b_pass valid=%0b data=%h beats=%0d exp 1/2222/2",
               out_valid, out_data, out_beats);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bubble valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    send_beat(16'h5A5A, 2'b01, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5A5A || out_beats !== 16'd1) begin
      errors++;
      $display("FAIL b2b_second valid=%0b data=%h beats=%0d exp 1/5A5A/1",
               out_valid, out_data, out_beats);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drained got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_saturate();
    logic early;
    early     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    op        = 2'b01;
    for (int i = 0; i < 70000; i++) begin
      in_last = (i == 69999);
      if (!in_ready || out_valid) early = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL sat_stream_stall got=%0b exp=0", early);
    end
    checks++;
    if (out_valid !== 1'b1 || out_beats !== 16'hFFFF || out_data !== 16'h0001) begin
      errors++;
      $display("FAIL sat_result valid=%0b data=%h beats=%h exp 1/0001/FFFF",
               out_valid, out_data, out_beats);
    end
`ifdef DL_BITWISE_ACC_POPCNT_EN
    checks++;
    if (out_popcnt !== 8'h01) begin
      errors++; $display("FAIL sat_popcnt got=%h exp=01", out_popcnt);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    op        = 2'b00;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_or();
    test_xor_op_ignored();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
